gpio_pad_bank_ctrl: RTL and testbench

Parametrised controller for a bank of NCH sky130 GPIO v2 pads. Sits between core logic and the pad ring. Owns the pad power-up enable sequence, per-channel mode selection, a freeze/hold handshake, and input synchronisation with optional debounce. Replaces hand-wired, per-pad tie-offs with one sequenced, configurable block per bank.

---
 rtl/gpio_pad_bank_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_gpio_pad_bank_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_bank_ctrl.sv
// Power-up sequencer, mode mux, hold handshake and input conditioning for one bank of GPIO pads.
// Define GPIO_PAD_DEBOUNCE_EN to add a per-channel debounce counter after the input synchroniser.
module gpio_pad_bank_ctrl #(
  parameter int NCH     = 8,
  parameter int SEQ_CYC = 16,
  parameter int DB_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad_en_req,
  input  logic             hold_req,
  input  logic [2*NCH-1:0] cfg_mode,
  input  logic [NCH-1:0]   gpio_out,
  input  logic [NCH-1:0]   gpio_oe,
  output logic [NCH-1:0]   gpio_in,
  output logic             bank_ready,
  output logic             bank_held,
  output logic             pad_enable_h,
  output logic             pad_enable_vdda_h,
  output logic             pad_enable_inp_h,
  output logic             pad_hold_h,
  output logic [NCH-1:0]   pad_out,
  output logic [NCH-1:0]   pad_oe_n,
  input  logic [NCH-1:0]   pad_in
);

  typedef enum logic [2:0] {
    S_OFF, S_SEQ_H, S_SEQ_VDDA, S_SEQ_INP,
    S_READY, S_HOLD_ENTER, S_HOLD, S_HOLD_EXIT
  } state_t;

  localparam int CW = (SEQ_CYC > 1) ? $clog2(SEQ_CYC) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(SEQ_CYC - 1);

  state_t          state;
  logic [CW-1:0]   step_cnt;
  logic [NCH-1:0]  oe_eff;
  logic [NCH-1:0]  in_en;
  logic [NCH-1:0]  in_en_hold;
  logic [NCH-1:0]  in_gate;
  logic [NCH-1:0]  sync_p0;
  logic [NCH-1:0]  sync_p1;
  logic [NCH-1:0]  cond;
  logic            io_active;
  logic            in_hold;

  // Mode decode: bit 0 of each mode field selects the input path.
  always_comb begin
    oe_eff = '0;
    in_en  = '0;
    for (int i = 0; i < NCH; i++) begin
      in_en[i] = cfg_mode[2*i];
      case (cfg_mode[2*i +: 2])
        2'b10:   oe_eff[i] = 1'b1;
        2'b11:   oe_eff[i] = gpio_oe[i];
        default: oe_eff[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_OFF;
      step_cnt          <= '0;
      pad_enable_h      <= 1'b0;
      pad_enable_vdda_h <= 1'b0;
      pad_enable_inp_h  <= 1'b0;
      pad_hold_h        <= 1'b0;
      bank_ready        <= 1'b0;
      bank_held         <= 1'b0;
      pad_out           <= '0;
      pad_oe_n          <= '1;
      in_en_hold        <= '0;
    end else if (state != S_OFF && !pad_en_req) begin
      // Bank power-down overrides everything, including a pending hold.
      state             <= S_OFF;
      step_cnt          <= '0;
      pad_enable_h      <= 1'b0;
      pad_enable_vdda_h <= 1'b0;
      pad_enable_inp_h  <= 1'b0;
      pad_hold_h        <= 1'b0;
      bank_ready        <= 1'b0;
      bank_held         <= 1'b0;
      pad_out           <= '0;
      pad_oe_n          <= '1;
    end else begin
      case (state)
        S_OFF: begin
          if (pad_en_req) begin
            state        <= S_SEQ_H;
            step_cnt     <= '0;
            pad_enable_h <= 1'b1;
          end
        end
        S_SEQ_H: begin
          if (step_cnt == STEP_LAST) begin
            state             <= S_SEQ_VDDA;
            step_cnt          <= '0;
            pad_enable_vdda_h <= 1'b1;
          end else begin
            step_cnt <= step_cnt + CW'(1);
          end
        end
        S_SEQ_VDDA: begin
          if (step_cnt == STEP_LAST) begin
            state            <= S_SEQ_INP;
            step_cnt         <= '0;
            pad_enable_inp_h <= 1'b1;
          end else begin
            step_cnt <= step_cnt + CW'(1);
          end
        end
        S_SEQ_INP: begin
          if (step_cnt == STEP_LAST) begin
            state      <= S_READY;
            step_cnt   <= '0;
            bank_ready <= 1'b1;
            pad_out    <= gpio_out;
            pad_oe_n   <= ~oe_eff;
          end else begin
            step_cnt <= step_cnt + CW'(1);
          end
        end
        S_READY: begin
          if (hold_req) begin
            // pad_out/pad_oe_n keep their current values from here on.
            state      <= S_HOLD_ENTER;
            bank_ready <= 1'b0;
            in_en_hold <= in_en;
          end else begin
            pad_out  <= gpio_out;
            pad_oe_n <= ~oe_eff;
          end
        end
        S_HOLD_ENTER: begin
          state      <= S_HOLD;
          pad_hold_h <= 1'b1;
          bank_held  <= 1'b1;
        end
        S_HOLD: begin
          if (!hold_req) begin
            state      <= S_HOLD_EXIT;
            pad_hold_h <= 1'b0;
            bank_held  <= 1'b0;
          end
        end
        S_HOLD_EXIT: begin
          state      <= S_READY;
          bank_ready <= 1'b1;
          pad_out    <= gpio_out;
          pad_oe_n   <= ~oe_eff;
        end
        default: state <= S_OFF;
      endcase
    end
  end

  // Input stage boundary: two-flop synchroniser on the raw pad inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pad_in;
      sync_p1 <= sync_p0;
    end
  end

`ifdef GPIO_PAD_DEBOUNCE_EN
  logic [DB_W-1:0] db_cnt [NCH];
  logic [NCH-1:0]  db_val;

  // Debounce stage boundary: a change is accepted only after 2^DB_W stable cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_val <= '0;
      for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync_p1[i] == db_val[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == {DB_W{1'b1}}) begin
          db_val[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign cond = db_val;
`else
  localparam int unused_db_w = DB_W;
  assign cond = sync_p1;
`endif

  assign io_active = (state == S_READY) || (state == S_HOLD_ENTER) ||
                     (state == S_HOLD)  || (state == S_HOLD_EXIT);
  assign in_hold   = (state == S_HOLD_ENTER) || (state == S_HOLD) || (state == S_HOLD_EXIT);

  always_comb begin
    in_gate = in_hold ? in_en_hold : in_en;
    gpio_in = io_active ? (cond & in_gate) : '0;
  end

endmodule

// File: tb/tb_gpio_pad_bank_ctrl.sv
// Directed bench for gpio_pad_bank_ctrl: sequencing, modes, hold, abort, async reset,
// and debounce when GPIO_PAD_DEBOUNCE_EN is defined.
module tb_gpio_pad_bank_ctrl;
  localparam int NCH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pad_en_req;
  logic             hold_req;
  logic [2*NCH-1:0] cfg_mode;
  logic [NCH-1:0]   gpio_out;
  logic [NCH-1:0]   gpio_oe;
  logic [NCH-1:0]   gpio_in;
  logic             bank_ready;
  logic             bank_held;
  logic             pad_enable_h;
  logic             pad_enable_vdda_h;
  logic             pad_enable_inp_h;
  logic             pad_hold_h;
  logic [NCH-1:0]   pad_out;
  logic [NCH-1:0]   pad_oe_n;
  logic [NCH-1:0]   pad_in;

  int checks   = 0;
  int failures = 0;

  gpio_pad_bank_ctrl #(.NCH(NCH), .SEQ_CYC(16), .DB_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pad_en_req(pad_en_req), .hold_req(hold_req),
    .cfg_mode(cfg_mode), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_in(gpio_in),
    .bank_ready(bank_ready), .bank_held(bank_held), .pad_enable_h(pad_enable_h),
    .pad_enable_vdda_h(pad_enable_vdda_h), .pad_enable_inp_h(pad_enable_inp_h),
    .pad_hold_h(pad_hold_h), .pad_out(pad_out), .pad_oe_n(pad_oe_n), .pad_in(pad_in)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; pad_en_req = 1'b0; hold_req = 1'b0;
    cfg_mode = 16'h00E4; gpio_out = 8'hFF; gpio_oe = 8'h00; pad_in = 8'h00;
    tick(2);
    chk("rst_en_h", 32'(pad_enable_h), 32'd0);
    chk("rst_oe_n", 32'(pad_oe_n), 32'hFF);
    chk("rst_out", 32'(pad_out), 32'h00);
    chk("rst_ready", 32'(bank_ready), 32'd0);
    chk("rst_gpio_in", 32'(gpio_in), 32'h00);

    // Power-up sequence: edges counted from the first edge that sees pad_en_req high.
    rst_n = 1'b1;
    tick(1);
    chk("off_idle_en_h", 32'(pad_enable_h), 32'd0);
    pad_en_req = 1'b1;
    tick(1);
    chk("seq_en_h_c1", 32'(pad_enable_h), 32'd1);
    chk("seq_vdda_c1", 32'(pad_enable_vdda_h), 32'd0);
    tick(15);
    chk("seq_vdda_c16", 32'(pad_enable_vdda_h), 32'd0);
    tick(1);
    chk("seq_vdda_c17", 32'(pad_enable_vdda_h), 32'd1);
    chk("seq_inp_c17", 32'(pad_enable_inp_h), 32'd0);
    chk("seq_oe_n", 32'(pad_oe_n), 32'hFF);
    tick(15);
    chk("seq_inp_c32", 32'(pad_enable_inp_h), 32'd0);
    tick(1);
    chk("seq_inp_c33", 32'(pad_enable_inp_h), 32'd1);
    tick(15);
    chk("seq_ready_c48", 32'(bank_ready), 32'd0);
    tick(1);
    chk("seq_ready_c49", 32'(bank_ready), 32'd1);
    chk("seq_en_h_kept", 32'(pad_enable_h), 32'd1);

    // Modes ch3..0 = 11,10,01,00; upper channels off.
    chk("mode_oe_n", 32'(pad_oe_n), 32'hFB);
    chk("mode_out", 32'(pad_out), 32'hFF);
    gpio_oe = 8'h0C;
    tick(1);
    chk("mode_bidir_oe", 32'(pad_oe_n), 32'hF3);
`ifndef GPIO_PAD_DEBOUNCE_EN
    pad_in = 8'hFF;
    tick(1);
    chk("in_lat1", 32'(gpio_in), 32'h00);
    tick(1);
    chk("in_lat2", 32'(gpio_in), 32'h0A);
    pad_in = 8'h00;
    tick(2);
    chk("in_fall", 32'(gpio_in), 32'h00);
`else
    pad_in = 8'h02;
    tick(10);
    pad_in = 8'h00;
    tick(30);
    chk("db_glitch", 32'(gpio_in), 32'h00);
    pad_in = 8'h02;
    tick(17);
    chk("db_c17", 32'(gpio_in), 32'h00);
    tick(1);
    chk("db_c18", 32'(gpio_in), 32'h02);
    tick(2);
    pad_in = 8'h00;
    tick(20);
    chk("db_release", 32'(gpio_in), 32'h00);
`endif

    // Hold entry/exit with output freeze and mode change ignored while held.
    gpio_out = 8'hA5;
    tick(1);
    chk("hold_pre_out", 32'(pad_out), 32'hA5);
    hold_req = 1'b1;
    tick(1);
    gpio_out = 8'h00;
    cfg_mode = 16'hAAAA;
    chk("hold_enter_h", 32'(pad_hold_h), 32'd0);
    chk("hold_enter_ready", 32'(bank_ready), 32'd0);
    tick(1);
    chk("hold_h", 32'(pad_hold_h), 32'd1);
    chk("hold_held", 32'(bank_held), 32'd1);
    chk("hold_out_frozen", 32'(pad_out), 32'hA5);
    tick(2);
    chk("hold_oe_frozen", 32'(pad_oe_n), 32'hF3);
    chk("hold_out_frozen2", 32'(pad_out), 32'hA5);
    hold_req = 1'b0;
    tick(1);
    chk("exit_h", 32'(pad_hold_h), 32'd0);
    chk("exit_out_frozen", 32'(pad_out), 32'hA5);
    tick(1);
    chk("exit_out_resume", 32'(pad_out), 32'h00);
    chk("exit_oe_resume", 32'(pad_oe_n), 32'h00);
    chk("exit_ready", 32'(bank_ready), 32'd1);

    // hold_req dropped during HOLD_ENTER still completes the hold.
    hold_req = 1'b1;
    tick(1);
    hold_req = 1'b0;
    tick(1);
    chk("short_hold_h", 32'(pad_hold_h), 32'd1);
    tick(1);
    chk("short_exit_h", 32'(pad_hold_h), 32'd0);
    tick(1);
    chk("short_ready", 32'(bank_ready), 32'd1);

    // Abort from HOLD.
    gpio_out = 8'h3C;
    hold_req = 1'b1;
    tick(2);
    chk("abort_pre_h", 32'(pad_hold_h), 32'd1);
    pad_en_req = 1'b0;
    tick(1);
    hold_req = 1'b0;
    chk("abort_en", 32'({pad_enable_h, pad_enable_vdda_h, pad_enable_inp_h}), 32'd0);
    chk("abort_hold_h", 32'(pad_hold_h), 32'd0);
    chk("abort_oe_n", 32'(pad_oe_n), 32'hFF);
    chk("abort_out", 32'(pad_out), 32'h00);
    chk("abort_held", 32'(bank_held), 32'd0);

    // Async reset in the middle of SEQ_VDDA.
    pad_en_req = 1'b1;
    tick(20);
    chk("ar_pre_vdda", 32'(pad_enable_vdda_h), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_en_h", 32'(pad_enable_h), 32'd0);
    chk("ar_vdda", 32'(pad_enable_vdda_h), 32'd0);
    chk("ar_oe_n", 32'(pad_oe_n), 32'hFF);
    chk("ar_ready", 32'(bank_ready), 32'd0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
